// File: rtl/mag_window_monitor.sv
// Sliding-window moving average (2^LOG2_WIN samples) with a hysteretic threshold alarm.
// Optional peak-hold register when MAG_PEAK_HOLD_EN is defined; otherwise peak_out reads 0.
module mag_window_monitor #(
    parameter int unsigned LOG2_WIN = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] mag_in,
    input  logic       mag_valid,
    input  logic       clear,
    input  logic [7:0] thresh_hi,
    input  logic [7:0] thresh_lo,
    output logic [7:0] avg_out,
    output logic       avg_valid,
    output logic       alarm,
    output logic [7:0] peak_out
);

    localparam int unsigned WIN = 1 << LOG2_WIN;
    localparam int unsigned SW  = 8 + LOG2_WIN;
    localparam logic [LOG2_WIN:0] WIN_CNT = (LOG2_WIN + 1)'(WIN);

    typedef enum logic [1:0] {
        FILL,
        NORMAL,
        ALARM
    } state_t;

    logic [7:0]          win_buf_q [WIN];
    logic [7:0]          win_buf_d [WIN];
    logic [LOG2_WIN-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG2_WIN:0]   cnt_q, cnt_d;
    logic [SW-1:0]       sum_q, sum_d;
    state_t              state_q, state_d;
    logic                alarm_q, alarm_d;
    logic                full;

    assign full      = (cnt_q == WIN_CNT);
    assign avg_out   = sum_q[SW-1:LOG2_WIN];
    assign avg_valid = full;
    assign alarm     = alarm_q;

    always_comb begin
        win_buf_d = win_buf_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        state_d   = state_q;

        if (ena) begin
            if (clear) begin
                // Buffer is left stale; it is never subtracted until refilled.
                wr_ptr_d = '0;
                cnt_d    = '0;
                sum_d    = '0;
                state_d  = FILL;
            end else begin
                if (mag_valid) begin
                    win_buf_d[wr_ptr_q] = mag_in;
                    wr_ptr_d            = wr_ptr_q + LOG2_WIN'(1);
                    if (!full) begin
                        sum_d = sum_q + SW'(mag_in);
                        cnt_d = cnt_q + (LOG2_WIN + 1)'(1);
                    end else begin
                        sum_d = sum_q + SW'(mag_in) - SW'(win_buf_q[wr_ptr_q]);
                    end
                end

                // Thresholds compare against the registered average, giving the extra cycle of alarm latency.
                case (state_q)
                    FILL:    if (full) state_d = NORMAL;
                    NORMAL:  if (avg_out >= thresh_hi) state_d = ALARM;
                    ALARM:   if (avg_out < thresh_lo) state_d = NORMAL;
                    default: state_d = FILL;
                endcase
            end
        end

        alarm_d = (state_d == ALARM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            sum_q    <= '0;
            state_q  <= FILL;
            alarm_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            state_q  <= state_d;
            alarm_q  <= alarm_d;
        end
    end

    always_ff @(posedge clk) begin
        win_buf_q <= win_buf_d;
    end

`ifdef MAG_PEAK_HOLD_EN
    logic [7:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (ena) begin
            if (clear) begin
                peak_d = '0;
            end else if (mag_valid && (mag_in > peak_q)) begin
                peak_d = mag_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_out = peak_q;
`else
    assign peak_out = '0;
`endif

endmodule

// File: tb/tb_mag_window_monitor.sv
// Directed bench for mag_window_monitor (LOG2_WIN=2): averaging, hysteresis, clear, reset, enable, peak hold.
module tb_mag_window_monitor;

`ifdef MAG_PEAK_HOLD_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] mag_in;
    logic       mag_valid;
    logic       clear;
    logic [7:0] thresh_hi;
    logic [7:0] thresh_lo;
    logic [7:0] avg_out;
    logic       avg_valid;
    logic       alarm;
    logic [7:0] peak_out;

    int n_tests = 0;
    int n_fail  = 0;

    mag_window_monitor #(.LOG2_WIN(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .mag_in    (mag_in),
        .mag_valid (mag_valid),
        .clear     (clear),
        .thresh_hi (thresh_hi),
        .thresh_lo (thresh_lo),
        .avg_out   (avg_out),
        .avg_valid (avg_valid),
        .alarm     (alarm),
        .peak_out  (peak_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pk(input int v);
        return PEAK_EN ? v : 0;
    endfunction

    // One clock with a sample strobe; outputs are sampled 1 time unit after the edge.
    task automatic send(input logic [7:0] d);
        mag_in    = d;
        mag_valid = 1'b1;
        @(posedge clk);
        #1;
        mag_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear     = 1'b1;
        mag_valid = 1'b1;
        mag_in    = 8'd200;
        @(posedge clk);
        #1;
        clear     = 1'b0;
        mag_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input int avg, input int vld, input int alm, input int peak);
        check({tag, ".avg"},   int'(avg_out),   avg);
        check({tag, ".valid"}, int'(avg_valid), vld);
        check({tag, ".alarm"}, int'(alarm),     alm);
        check({tag, ".peak"},  int'(peak_out),  pk(peak));
    endtask

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        mag_in    = '0;
        mag_valid = 1'b0;
        clear     = 1'b0;
        thresh_hi = 8'd30;
        thresh_lo = 8'd20;

        #3;
        expect_out("reset", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill: sums 10,30,60,100
        send(8'd10); expect_out("fill1", 2,  0, 0, 10);
        send(8'd20); expect_out("fill2", 7,  0, 0, 20);
        send(8'd30); expect_out("fill3", 15, 0, 0, 30);
        send(8'd40); expect_out("fill4", 25, 1, 0, 40);

        // Slide: 140,120,90,50,0; FILL->NORMAL on the 50 edge, alarm evaluated from the next edge
        send(8'd50); expect_out("slide50", 35, 1, 0, 50);
        send(8'd0);  expect_out("slide0a", 30, 1, 1, 50);
        send(8'd0);  expect_out("slide0b", 22, 1, 1, 50);
        send(8'd0);  expect_out("slide0c", 12, 1, 1, 50);
        send(8'd0);  expect_out("slide0d", 0,  1, 0, 50);

        do_clear();  expect_out("clear", 0, 0, 0, 0);

        send(8'd4);  expect_out("post_clr1", 1, 0, 0, 4);
        send(8'd4);
        send(8'd4);
        send(8'd4);  expect_out("post_clr4", 4, 1, 0, 4);

        ena = 1'b0;
        send(8'd255);
        send(8'd255);
        do_clear();
        send(8'd255); expect_out("ena_off", 4, 1, 0, 4);
        ena = 1'b1;

        do_clear();
        send(8'd7);  expect_out("peak7",  1,  0, 0, 7);
        send(8'd90); expect_out("peak90", 24, 0, 0, 90);
        send(8'd3);  expect_out("peak3",  25, 0, 0, 90);

        // Asynchronous reset between edges, then a fresh window
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_rst", 0, 0, 0, 0);
        #1;
        rst_n = 1'b1;
        send(8'd8);  expect_out("rst_new1", 2, 0, 0, 8);
        send(8'd8);
        send(8'd8);
        send(8'd8);  expect_out("rst_new4", 8, 1, 0, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
